// File: rtl/tb_harness_pkg.sv
// Shared constants and state type for the instruction ROM / end-of-program monitor.
package tb_harness_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP               = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mon_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program word array: synchronous load port, combinational fetch port that
// returns NOP for misaligned or out-of-window addresses.
module prog_mem
  import tb_harness_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [31:0]              raddr_i,
  output logic [31:0]              rdata_o,
  output logic                     in_range_o,
  output logic                     aligned_o
);

  localparam int          IW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   offset;
  logic [IW-1:0] ridx;

  // Addresses below the base wrap to huge offsets, so one unsigned compare covers both bounds.
  assign offset     = raddr_i - BASE_ADDR;
  assign in_range_o = offset < SPAN;
  assign aligned_o  = raddr_i[1:0] == 2'b00;
  assign ridx       = offset[IW+1:2];
  assign rdata_o    = (in_range_o && aligned_o) ? mem_q[ridx] : NOP;

  // NOTE: no reset on the array; a program written while reset is held must survive into the run.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_rom_monitor.sv
// Instruction ROM served at the reset vector plus halt/timeout checker that
// grades register_v0 and counts RUN cycles.
module instr_rom_monitor
  import tb_harness_pkg::*;
#(
  parameter int          DEPTH          = 64,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter logic [31:0] HALT_ADDR      = DEFAULT_HALT_ADDR,
  parameter int          TIMEOUT_CYCLES = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_index,
  input  logic [31:0]              load_data,
  input  logic [31:0]              instr_address,
  output logic [31:0]              instr_readdata,
  input  logic                     active,
  input  logic [31:0]              register_v0,
  input  logic [31:0]              expected_v0,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic                     fetch_error,
  output logic [31:0]              cycle_count
);

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

  logic        in_range, aligned;
  logic        in_run, at_halt_addr, halt, bad_fetch, expired;
  mon_state_t  state_q;
  logic        done_q, pass_q, timeout_q, fetch_error_q;
  logic [31:0] cycle_count_q, cycle_count_d;

  prog_mem #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_prog_mem (
    .clk       (clk),
    .we_i      (load_en && reset),
    .waddr_i   (load_index),
    .wdata_i   (load_data),
    .raddr_i   (instr_address),
    .rdata_o   (instr_readdata),
    .in_range_o(in_range),
    .aligned_o (aligned)
  );

  assign in_run        = state_q == RUN;
  assign at_halt_addr  = instr_address == HALT_ADDR;
  assign halt          = in_run && (cycle_count_q != 32'd0) && (at_halt_addr || !active);
  assign bad_fetch     = in_run && !at_halt_addr && !(in_range && aligned);
  assign expired       = in_run && (cycle_count_q == LAST_CYCLE);
  assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 32'd1;

  // NOTE: every register here is assigned with <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fetch_error_q <= 1'b0;
      cycle_count_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: state_q <= RUN;
        RUN: begin
          cycle_count_q <= cycle_count_d;
          if (bad_fetch) begin
            fetch_error_q <= 1'b1;
          end
          // Halt takes priority over a timeout landing on the same edge.
          if (halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (register_v0 == expected_v0) && !(fetch_error_q || bad_fetch);
          end else if (expired) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fetch_error = fetch_error_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_instr_rom_monitor.sv
// Directed bench for instr_rom_monitor: table of fetch vectors plus hand-built
// halt, timeout, mid-run reset and halt/timeout-coincidence sequences.
module tb_instr_rom_monitor;
  import tb_harness_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam logic [31:0] HALT  = 32'h0000_0000;
  localparam int          TO    = 50;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_index;
  logic [31:0] load_data;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] expected_v0;
  logic        done, pass, timeout, fetch_error;
  logic [31:0] cycle_count;

  instr_rom_monitor #(
    .DEPTH         (DEPTH),
    .BASE_ADDR     (BASE),
    .HALT_ADDR     (HALT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_index    (load_index),
    .load_data     (load_data),
    .instr_address (instr_address),
    .instr_readdata(instr_readdata),
    .active        (active),
    .register_v0   (register_v0),
    .expected_v0   (expected_v0),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fetch_error   (fetch_error),
    .cycle_count   (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        ferr;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] bltzal [13];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a[1:0] != 2'b00 || off >= 32'(4 * DEPTH)) return 32'h0;
    return model_mem[off[7:2]];
  endfunction

  task automatic fetch(input logic [31:0] a);
    instr_address = a;
    exp_q.push_back(model_read(a));
    #1;
    check("readdata", instr_readdata, exp_q.pop_front());
  endtask

  // Only called while reset is high, so the model always takes the write.
  task automatic load_word(input int idx, input logic [31:0] data);
    load_en    = 1'b1;
    load_index = 6'(idx);
    load_data  = data;
    tick();
    model_mem[idx] = data;
    load_en = 1'b0;
  endtask

  task automatic wait_count(input logic [31:0] target, input int budget);
    int n = 0;
    while (cycle_count !== target && n < budget) begin
      tick();
      n++;
    end
    check("wait_count", cycle_count, target);
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bltzal = '{32'h2402_0000, 32'h2408_000A, 32'h2409_0000, 32'h0510_0004,
               32'h0000_0000, 32'h2442_000A, 32'h2529_0001, 32'h1528_FFFD,
               32'h0000_0000, 32'h2442_0028, 32'h03E0_0008, 32'h0000_0000,
               32'h2400_0000};
    reset = 1'b1;  load_en = 1'b0;  load_index = '0;  load_data = '0;
    instr_address = BASE | 32'd1;  active = 1'b1;
    register_v0 = '0;  expected_v0 = 32'd140;
    tick();
    tick();
    check("rst_done",  done,        0);
    check("rst_pass",  pass,        0);
    check("rst_tmo",   timeout,     0);
    check("rst_ferr",  fetch_error, 0);
    check("rst_count", cycle_count, 0);

    for (int i = 0; i < 13; i++) load_word(i, bltzal[i]);
    load_word(63, 32'hDEAD_BEEF);
    fetch(BASE);
    instr_address = BASE | 32'd1;
    reset = 1'b0;
    tick();
    check("ferr_idle", fetch_error, 0);

    // Program run ending in jr to 0 with matching v0.
    for (int i = 0; i < 13; i++) begin
      fetch(BASE + 32'(4 * i));
      register_v0 = (i == 12) ? 32'd140 : 32'(10 * i);
      tick();
    end
    instr_address = HALT;
    tick();
    check("t1_done",  done,        1);
    check("t1_pass",  pass,        1);
    check("t1_tmo",   timeout,     0);
    check("t1_ferr",  fetch_error, 0);
    check("t1_count", cycle_count, 14);
    tick();
    tick();
    check("t1_done_hold", done,        1);
    check("t1_frozen",    cycle_count, 14);

    // Same program, wrong expectation, halt via active low; load in RUN is ignored.
    expected_v0   = 32'd139;
    instr_address = BASE;
    reset = 1'b1;
    tick();
    check("t2_done_clr", done, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      fetch(BASE + 32'(4 * i));
      if (i == 2) begin
        load_en = 1'b1;  load_index = 6'd6;  load_data = 32'h1111_1111;
      end
      tick();
      load_en = 1'b0;
    end
    fetch(BASE + 32'd24);
    tick();
    fetch(BASE + 32'd28);
    active      = 1'b0;
    register_v0 = 32'd140;
    tick();
    active = 1'b1;
    check("t2_done", done,    1);
    check("t2_pass", pass,    0);
    check("t2_tmo",  timeout, 0);

    // Fetch table: in-window reads, then misaligned and out-of-window NOPs.
    vecs[0] = '{BASE,          bltzal[0],    1'b0};
    vecs[1] = '{BASE + 32'd4,  bltzal[1],    1'b0};
    vecs[2] = '{BASE + 32'd48, bltzal[12],   1'b0};
    vecs[3] = '{BASE + 32'd252, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{BASE + 32'd2,  32'h0,        1'b1};
    vecs[5] = '{BASE + 32'd256, 32'h0,       1'b1};
    vecs[6] = '{BASE - 32'd4,  32'h0,        1'b1};
    expected_v0   = 32'd140;
    instr_address = BASE;
    restart();
    for (int i = 0; i < 7; i++) begin
      instr_address = vecs[i].addr;
      exp_q.push_back(vecs[i].data);
      #1;
      check($sformatf("vec%0d_data", i), instr_readdata, exp_q.pop_front());
      tick();
      check($sformatf("vec%0d_ferr", i), fetch_error, vecs[i].ferr);
    end
    instr_address = HALT;
    register_v0   = 32'd140;
    tick();
    check("t3_done", done, 1);
    check("t3_pass", pass, 0);

    // Branch-to-self until timeout.
    reset = 1'b1;
    load_word(0, 32'h1000_FFFF);
    instr_address = BASE;
    reset = 1'b0;
    tick();
    fetch(BASE);
    wait_count(32'(TO - 1), 100);
    check("t4_done_pre", done, 0);
    tick();
    check("t4_done",  done,        1);
    check("t4_tmo",   timeout,     1);
    check("t4_pass",  pass,        0);
    check("t4_count", cycle_count, 50);
    tick();
    check("t4_frozen", cycle_count, 50);

    // Reset mid-run while loading a new word.
    instr_address = BASE;
    restart();
    instr_address = BASE + 32'd2;
    tick();
    check("t5_ferr_set", fetch_error, 1);
    instr_address = BASE + 32'd4;
    wait_count(32'd10, 50);
    reset = 1'b1;
    load_word(5, 32'hCAFE_F00D);
    check("t5_done",  done,        0);
    check("t5_ferr",  fetch_error, 0);
    check("t5_count", cycle_count, 0);
    reset = 1'b0;
    tick();
    fetch(BASE + 32'd20);
    check("t5_count_run0", cycle_count, 0);
    tick();
    check("t5_count_run1", cycle_count, 1);

    // Halt address ignored at count 0; halt and timeout on the same edge.
    instr_address = BASE;
    restart();
    instr_address = HALT;
    tick();
    check("t6_no_early_halt", done,        0);
    check("t6_halt_exempt",   fetch_error, 0);
    instr_address = BASE;
    wait_count(32'(TO - 1), 100);
    instr_address = HALT;
    register_v0   = 32'd140;
    tick();
    check("t6_done",  done,        1);
    check("t6_tmo",   timeout,     0);
    check("t6_pass",  pass,        1);
    check("t6_count", cycle_count, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
